ob_sorted_table: RTL and testbench
==================================

# ob_sorted_table

Parametrised, price-sorted order-book side table holding up to N resting orders (`ob_pkg::table_t`), ordered best-first with FIFO tie-break. It is instantiated twice in the order-book engine, once as the bid side and once as the ask side. It generalises the single-entry TABLE_BID_INIT/TABLE_ASK_INIT register to N-deep storage. It supports insert, pop-top, cancel-by-UID and partial fill of the head, each with a registered response under valid/accept backpressure.

## Interface
- N, 16: table depth, ≥2.
- IS_BID, 1: 1 = bid (descending price best-first); 0 = ask (ascending).
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- cmd_vld  in  1  command valid.
- cmd_op  in  2  `ob_pkg::table_op_t`: Tbl_Insert, Tbl_PopTop, Tbl_Cancel, Tbl_HeadDec.
- cmd_entry  in  table_t  payload: Insert uses all fields; Cancel uses uid; HeadDec uses quantity.
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
- rsp_vld  out  1  response valid.
- rsp_accept  in  1  response consumed.
- rsp_status  out  `ob_pkg::status_t`  result status.
- rsp_entry  out  table_t  affected entry.
- head_vld  out  1  table non-empty.
- head  out  table_t  best entry; INIT value when empty.
- count  out  $clog2(N+1)  occupancy.
- full, empty  out  1  count==N / count==0.

## Operation
- Storage: N slots, each valid bit + table_t; valid slots are contiguous from slot 0; slot 0 is the head.
- Price compare: unsigned compare of packed BCD price_t (BCD is monotonic). "Better" = greater (bid) or lesser (ask).
- Tbl_Insert:
  - Reject (S_Reject, no change) if full, quantity==0 or uid=='1.
  - Else new entry goes after every valid entry with better-or-equal price (FIFO at equal price); later entries shift down one. Response S_Okay, rsp_entry = inserted entry.
- Tbl_PopTop:
  - Empty → S_BadPop, rsp_entry = INIT.
  - Else rsp_entry = head, S_Okay, all entries shift up one.
- Tbl_Cancel:
  - Parallel UID match over valid slots. Hit: the lowest-index match is removed, later entries shift up, S_CancelHit, rsp_entry = removed entry.
  - Miss: S_CancelMiss, rsp_entry = cmd_entry.
- Tbl_HeadDec (q = cmd_entry.quantity, arithmetic in quantity_arith_t):
  - Empty, q==0 or q > head.quantity → S_Bad, no change.
  - q < head.quantity → head.quantity -= q, S_Okay, rsp_entry = updated head.
  - q == head.quantity → head removed as PopTop, S_Okay, rsp_entry = head with quantity 0.
- Vacated slots are written with the INIT value (TABLE_BID_INIT or TABLE_ASK_INIT per IS_BID) and their valid bit cleared.

## Timing
- Reset (async assert, sync release): all slots INIT/invalid; rsp_vld=0, rsp_status=S_Okay, rsp_entry=INIT, head=INIT, head_vld=0, count=0, empty=1, full=0, cmd_rdy=1.
- cmd_rdy = !rsp_vld | rsp_accept (combinational). Table update and response register occur on the accept edge.
- Latency: 1 cycle. The response is visible the cycle after accept; head/count/full/empty reflect the command in that same cycle.
- Back-to-back commands at one per cycle are allowed while rsp_accept is held high. The next command always sees the previous command's update.
- rsp_* is held stable while rsp_vld & !rsp_accept.
- Reset mid-command discards the command and response; no partial update survives.

## Structure
- Add to ob_pkg:
  - `table_op_t` (2-bit enum).
  - `TABLE_INIT(is_bid)` selection via a function returning TABLE_BID_INIT or TABLE_ASK_INIT.
- Sub-module ob_sorted_table_cell:
  - One slot; inputs are its own, previous and next neighbours plus per-slot hold/shift-up/shift-down/load/decrement selects.
  - The top level computes the insert position (better-or-equal mask, priority encode) and the cancel match (priority encode).

## Test plan
- IS_BID=1, insert prices 100.00, 102.00, 101.00 (uids 1,2,3) → head uid 2. PopTop returns 2, then 3, then 1; a fourth PopTop → S_BadPop.
- IS_BID=0, insert uid 5 @ 50.00 then uid 6 @ 50.00 → head uid 5 (FIFO). Cancel uid 5 → S_CancelHit, head becomes uid 6. Cancel uid 9 → S_CancelMiss.
- N=4, fill 4 entries, then a fifth insert → S_Reject, count stays 4, full=1. Insert with qty 0 or uid 'hFFFFFFFF → S_Reject.
- Head qty 100: HeadDec 30 → qty 70, S_Okay. HeadDec 80 → S_Bad. HeadDec 70 → entry removed, rsp quantity 0, count decrements.
- Hold rsp_accept=0 for 3 cycles after a command → cmd_rdy=0 and rsp stable; raise accept with a new cmd_vld → back-to-back commands complete one per cycle.
- Assert arst_n low mid-stream with 3 entries → all outputs at reset values immediately; after release count=0 and head=INIT.

Source files
------------

// File: rtl/ob_pkg.sv
// rtl/ob_pkg.sv - shared order-book types, status codes and table init values
package ob_pkg;

  // Eight packed BCD digits, two of them fractional (e.g. 100.00 = 32'h0001_0000).
  typedef logic [31:0] price_t;
  typedef logic [31:0] quantity_t;
  // One guard bit so quantity comparisons and differences cannot wrap.
  typedef logic [32:0] quantity_arith_t;
  typedef logic [31:0] uid_t;

  typedef struct packed {
    uid_t      uid;
    price_t    price;
    quantity_t quantity;
  } table_t;

  typedef enum logic [2:0] {
    S_Okay       = 3'd0,
    S_Reject     = 3'd1,
    S_BadPop     = 3'd2,
    S_CancelHit  = 3'd3,
    S_CancelMiss = 3'd4,
    S_Bad        = 3'd5
  } status_t;

  typedef enum logic [1:0] {
    Tbl_Insert  = 2'd0,
    Tbl_PopTop  = 2'd1,
    Tbl_Cancel  = 2'd2,
    Tbl_HeadDec = 2'd3
  } table_op_t;

  // Per-slot update select driven by the table top level.
  typedef enum logic [2:0] {
    C_Hold      = 3'd0,
    C_ShiftUp   = 3'd1,
    C_ShiftDown = 3'd2,
    C_Load      = 3'd3,
    C_Dec       = 3'd4
  } cell_sel_t;

  // Empty slots hold the worst possible price for their side.
  localparam table_t TABLE_BID_INIT = '{uid: '1, price: 32'h0000_0000, quantity: '0};
  localparam table_t TABLE_ASK_INIT = '{uid: '1, price: 32'h9999_9999, quantity: '0};

  function automatic table_t table_init(input bit is_bid);
    return is_bid ? TABLE_BID_INIT : TABLE_ASK_INIT;
  endfunction

endpackage

// File: rtl/ob_sorted_table_if.sv
// rtl/ob_sorted_table_if.sv - command/response handshake bundle for one table side
interface ob_sorted_table_if;

  logic                cmd_vld;
  ob_pkg::table_op_t   cmd_op;
  ob_pkg::table_t      cmd_entry;
  logic                cmd_rdy;
  logic                rsp_vld;
  logic                rsp_accept;
  ob_pkg::status_t     rsp_status;
  ob_pkg::table_t      rsp_entry;

  modport master (
    output cmd_vld, cmd_op, cmd_entry, rsp_accept,
    input  cmd_rdy, rsp_vld, rsp_status, rsp_entry
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_entry, rsp_accept,
    output cmd_rdy, rsp_vld, rsp_status, rsp_entry
  );

endinterface

// File: rtl/ob_sorted_table_cell.sv
// rtl/ob_sorted_table_cell.sv - one storage slot of the sorted table
module ob_sorted_table_cell
  import ob_pkg::*;
#(
  parameter bit IS_BID = 1'b1
) (
  input  logic      clk,
  input  logic      arst_n,
  input  cell_sel_t sel,
  input  logic      prev_vld,
  input  table_t    prev_entry,
  input  logic      next_vld,
  input  table_t    next_entry,
  input  table_t    load_entry,
  input  quantity_t dec_qty,
  output logic      vld,
  output table_t    entry
);

  // Slot register: hold, take a neighbour, load a new entry or trim quantity.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld   <= 1'b0;
      entry <= table_init(IS_BID);
    end else begin
      case (sel)
        C_ShiftUp: begin
          vld   <= next_vld;
          entry <= next_entry;
        end
        C_ShiftDown: begin
          vld   <= prev_vld;
          entry <= prev_entry;
        end
        C_Load: begin
          vld   <= 1'b1;
          entry <= load_entry;
        end
        C_Dec: begin
          entry.quantity <= entry.quantity - dec_qty;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/ob_sorted_table.sv
// rtl/ob_sorted_table.sv - N-deep price-sorted order-book side with FIFO tie-break
module ob_sorted_table
  import ob_pkg::*;
#(
  parameter int N      = 16,
  parameter bit IS_BID = 1'b1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  ob_sorted_table_if.slave       bus,
  output logic                   head_vld,
  output table_t                 head,
  output logic [$clog2(N+1)-1:0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int     CW   = $clog2(N+1);
  localparam table_t INIT = table_init(IS_BID);

  logic [N-1:0]    slot_vld;
  table_t          slot_entry [N];
  cell_sel_t       slot_sel   [N];

  logic            accept;
  logic            rsp_vld_q;
  status_t         rsp_status_q;
  table_t          rsp_entry_q;
  logic [CW-1:0]   cnt_q;

  logic [CW-1:0]   ins_pos;
  logic [CW-1:0]   hit_pos;
  logic [CW-1:0]   rm_pos;
  logic            hit;
  table_t          hit_entry;
  logic            do_ins;
  logic            do_rm;
  logic            do_dec;
  status_t         nxt_status;
  table_t          nxt_entry;
  quantity_arith_t dec_q;
  quantity_arith_t head_q;

  assign bus.cmd_rdy = !rsp_vld_q || bus.rsp_accept;
  assign accept      = bus.cmd_vld && bus.cmd_rdy;

  assign dec_q  = quantity_arith_t'(bus.cmd_entry.quantity);
  assign head_q = quantity_arith_t'(slot_entry[0].quantity);

  // Insert position is the first slot not better-or-equal; cancel hits the first uid match.
  always_comb begin
    ins_pos   = CW'(N);
    hit       = 1'b0;
    hit_pos   = '0;
    hit_entry = INIT;
    for (int i = N - 1; i >= 0; i--) begin
      if (!(slot_vld[i] && (IS_BID ? (slot_entry[i].price >= bus.cmd_entry.price)
                                   : (slot_entry[i].price <= bus.cmd_entry.price)))) begin
        ins_pos = CW'(i);
      end
      if (slot_vld[i] && (slot_entry[i].uid == bus.cmd_entry.uid)) begin
        hit       = 1'b1;
        hit_pos   = CW'(i);
        hit_entry = slot_entry[i];
      end
    end
  end

  // Command decode: what the table does and what the response carries.
  always_comb begin
    do_ins     = 1'b0;
    do_rm      = 1'b0;
    do_dec     = 1'b0;
    rm_pos     = '0;
    nxt_status = S_Okay;
    nxt_entry  = bus.cmd_entry;
    case (bus.cmd_op)
      Tbl_Insert: begin
        if (full || (bus.cmd_entry.quantity == '0) || (bus.cmd_entry.uid == '1)) begin
          nxt_status = S_Reject;
        end else begin
          do_ins = 1'b1;
        end
      end
      Tbl_PopTop: begin
        if (!slot_vld[0]) begin
          nxt_status = S_BadPop;
          nxt_entry  = INIT;
        end else begin
          do_rm     = 1'b1;
          nxt_entry = slot_entry[0];
        end
      end
      Tbl_Cancel: begin
        if (hit) begin
          do_rm      = 1'b1;
          rm_pos     = hit_pos;
          nxt_status = S_CancelHit;
          nxt_entry  = hit_entry;
        end else begin
          nxt_status = S_CancelMiss;
        end
      end
      Tbl_HeadDec: begin
        if (!slot_vld[0] || (dec_q == '0) || (dec_q > head_q)) begin
          nxt_status = S_Bad;
        end else if (dec_q < head_q) begin
          do_dec             = 1'b1;
          nxt_entry          = slot_entry[0];
          nxt_entry.quantity = quantity_t'(head_q - dec_q);
        end else begin
          do_rm              = 1'b1;
          nxt_entry          = slot_entry[0];
          nxt_entry.quantity = '0;
        end
      end
    endcase
  end

  // Per-slot selects: open a gap at the insert point or close one at the removal point.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      slot_sel[i] = C_Hold;
      if (accept) begin
        if (do_ins) begin
          if (CW'(i) == ins_pos) begin
            slot_sel[i] = C_Load;
          end else if (CW'(i) > ins_pos) begin
            slot_sel[i] = C_ShiftDown;
          end
        end
        if (do_rm && (CW'(i) >= rm_pos)) begin
          slot_sel[i] = C_ShiftUp;
        end
        if (do_dec && (i == 0)) begin
          slot_sel[i] = C_Dec;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_slot
    logic   prev_vld;
    logic   next_vld;
    table_t prev_entry;
    table_t next_entry;

    if (g == 0) begin : g_first
      assign prev_vld   = 1'b0;
      assign prev_entry = INIT;
    end else begin : g_inner_prev
      assign prev_vld   = slot_vld[g-1];
      assign prev_entry = slot_entry[g-1];
    end

    // The last slot refills with an empty entry when the table shifts up.
    if (g == N - 1) begin : g_last
      assign next_vld   = 1'b0;
      assign next_entry = INIT;
    end else begin : g_inner_next
      assign next_vld   = slot_vld[g+1];
      assign next_entry = slot_entry[g+1];
    end

    ob_sorted_table_cell #(.IS_BID(IS_BID)) u_cell (
      .clk        (clk),
      .arst_n     (arst_n),
      .sel        (slot_sel[g]),
      .prev_vld   (prev_vld),
      .prev_entry (prev_entry),
      .next_vld   (next_vld),
      .next_entry (next_entry),
      .load_entry (bus.cmd_entry),
      .dec_qty    (bus.cmd_entry.quantity),
      .vld        (slot_vld[g]),
      .entry      (slot_entry[g])
    );
  end

  // Occupancy tracks inserts and removals on the accept edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      if (do_ins) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_rm) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Response register: load on accept, drop once consumed, otherwise hold.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rsp_vld_q    <= 1'b0;
      rsp_status_q <= S_Okay;
      rsp_entry_q  <= INIT;
    end else if (accept) begin
      rsp_vld_q    <= 1'b1;
      rsp_status_q <= nxt_status;
      rsp_entry_q  <= nxt_entry;
    end else if (bus.rsp_accept) begin
      rsp_vld_q    <= 1'b0;
    end
  end

  assign bus.rsp_vld    = rsp_vld_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_entry  = rsp_entry_q;

  assign head     = slot_entry[0];
  assign head_vld = slot_vld[0];
  assign count    = cnt_q;
  assign full     = (cnt_q == CW'(N));
  assign empty    = (cnt_q == '0);

endmodule

// File: tb/tb_ob_sorted_table.sv
// tb/tb_ob_sorted_table.sv - self-checking bench for bid (N=4) and ask (N=16) tables
module tb_ob_sorted_table;
  import ob_pkg::*;

  logic clk;
  logic arst_n;

  ob_sorted_table_if if_b ();
  ob_sorted_table_if if_a ();

  logic       hv_b, full_b, empty_b;
  logic       hv_a, full_a, empty_a;
  table_t     head_b, head_a;
  logic [2:0] count_b;
  logic [4:0] count_a;

  ob_sorted_table #(.N(4), .IS_BID(1'b1)) u_bid (
    .clk      (clk),
    .arst_n   (arst_n),
    .bus      (if_b),
    .head_vld (hv_b),
    .head     (head_b),
    .count    (count_b),
    .full     (full_b),
    .empty    (empty_b)
  );

  ob_sorted_table #(.N(16), .IS_BID(1'b0)) u_ask (
    .clk      (clk),
    .arst_n   (arst_n),
    .bus      (if_a),
    .head_vld (hv_a),
    .head     (head_a),
    .count    (count_a),
    .full     (full_a),
    .empty    (empty_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  table_t  m_e [2][16];
  int      m_n [2];
  status_t last_st;
  table_t  last_re;

  function automatic table_t init_of(input int d);
    return (d == 0) ? TABLE_BID_INIT : TABLE_ASK_INIT;
  endfunction

  function automatic price_t bcd(input int cents);
    price_t r;
    int     v;
    v = cents;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic table_t mk(input int uid, input int cents, input int qty);
    table_t t;
    t.uid      = uid_t'(uid);
    t.price    = bcd(cents);
    t.quantity = quantity_t'(qty);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input table_op_t op, input table_t e, input logic a);
    if (d == 0) begin
      if_b.cmd_vld = v; if_b.cmd_op = op; if_b.cmd_entry = e; if_b.rsp_accept = a;
    end else begin
      if_a.cmd_vld = v; if_a.cmd_op = op; if_a.cmd_entry = e; if_a.rsp_accept = a;
    end
  endtask

  task automatic snap(input int d, output logic rv, output status_t st, output table_t re,
                      output logic hv, output table_t hd, output logic [4:0] cnt,
                      output logic fl, output logic em, output logic rdy);
    if (d == 0) begin
      rv = if_b.rsp_vld; st = if_b.rsp_status; re = if_b.rsp_entry; rdy = if_b.cmd_rdy;
      hv = hv_b; hd = head_b; cnt = {2'b00, count_b}; fl = full_b; em = empty_b;
    end else begin
      rv = if_a.rsp_vld; st = if_a.rsp_status; re = if_a.rsp_entry; rdy = if_a.cmd_rdy;
      hv = hv_a; hd = head_a; cnt = count_a; fl = full_a; em = empty_a;
    end
  endtask

  task automatic m_remove(input int d, input int h);
    for (int k = h; k < m_n[d] - 1; k++) m_e[d][k] = m_e[d][k+1];
    m_n[d]--;
  endtask

  // Reference model: a sorted list where a newcomer queues behind equal prices.
  task automatic model_cmd(input int d, input table_op_t op, input table_t ce,
                           output status_t st, output table_t re);
    int cap;
    bit isb;
    int p;
    int h;
    cap = (d == 0) ? 4 : 16;
    isb = (d == 0);
    st  = S_Okay;
    re  = ce;
    case (op)
      Tbl_Insert: begin
        if (m_n[d] == cap || ce.quantity == 0 || ce.uid == 32'hFFFF_FFFF) begin
          st = S_Reject;
        end else begin
          p = m_n[d];
          for (int k = 0; k < m_n[d]; k++) begin
            if (isb ? (ce.price > m_e[d][k].price) : (ce.price < m_e[d][k].price)) begin
              p = k;
              break;
            end
          end
          for (int k = m_n[d]; k > p; k--) m_e[d][k] = m_e[d][k-1];
          m_e[d][p] = ce;
          m_n[d]++;
        end
      end
      Tbl_PopTop: begin
        if (m_n[d] == 0) begin
          st = S_BadPop;
          re = init_of(d);
        end else begin
          re = m_e[d][0];
          m_remove(d, 0);
        end
      end
      Tbl_Cancel: begin
        h = -1;
        for (int k = 0; k < m_n[d]; k++) begin
          if (m_e[d][k].uid == ce.uid) begin
            h = k;
            break;
          end
        end
        if (h < 0) begin
          st = S_CancelMiss;
        end else begin
          st = S_CancelHit;
          re = m_e[d][h];
          m_remove(d, h);
        end
      end
      Tbl_HeadDec: begin
        if (m_n[d] == 0 || ce.quantity == 0 || ce.quantity > m_e[d][0].quantity) begin
          st = S_Bad;
        end else if (ce.quantity < m_e[d][0].quantity) begin
          m_e[d][0].quantity = m_e[d][0].quantity - ce.quantity;
          re = m_e[d][0];
        end else begin
          re = m_e[d][0];
          re.quantity = 0;
          m_remove(d, 0);
        end
      end
    endcase
  endtask

  task automatic check_all(input int d, input string tag, input status_t st_e, input table_t re_e);
    logic rv, hv, fl, em, rdy;
    status_t st;
    table_t re, hd, hd_e;
    logic [4:0] cnt;
    int cap;
    cap  = (d == 0) ? 4 : 16;
    hd_e = (m_n[d] > 0) ? m_e[d][0] : init_of(d);
    snap(d, rv, st, re, hv, hd, cnt, fl, em, rdy);
    chk({tag, "_rsp_vld"}, 128'(rv), 128'(1'b1));
    chk({tag, "_status"},  128'(st), 128'(st_e));
    chk({tag, "_entry"},   128'(re), 128'(re_e));
    chk({tag, "_head"},    128'(hd), 128'(hd_e));
    chk({tag, "_head_vld"}, 128'(hv), 128'(m_n[d] > 0));
    chk({tag, "_count"},   128'(cnt), 128'(m_n[d]));
    chk({tag, "_full"},    128'(fl), 128'(m_n[d] == cap));
    chk({tag, "_empty"},   128'(em), 128'(m_n[d] == 0));
  endtask

  task automatic check_idle(input int d, input string tag);
    logic rv, hv, fl, em, rdy;
    status_t st;
    table_t re, hd;
    logic [4:0] cnt;
    snap(d, rv, st, re, hv, hd, cnt, fl, em, rdy);
    chk({tag, "_rsp_vld"}, 128'(rv), 128'(1'b0));
    chk({tag, "_status"},  128'(st), 128'(S_Okay));
    chk({tag, "_entry"},   128'(re), 128'(init_of(d)));
    chk({tag, "_head"},    128'(hd), 128'(init_of(d)));
    chk({tag, "_head_vld"}, 128'(hv), 128'(1'b0));
    chk({tag, "_count"},   128'(cnt), 128'(0));
    chk({tag, "_full"},    128'(fl), 128'(1'b0));
    chk({tag, "_empty"},   128'(em), 128'(1'b1));
    chk({tag, "_cmd_rdy"}, 128'(rdy), 128'(1'b1));
  endtask

  task automatic issue(input int d, input table_op_t op, input table_t ce, input string tag);
    logic rv, hv, fl, em, rdy;
    status_t st;
    table_t re, hd;
    logic [4:0] cnt;
    @(negedge clk);
    drive(d, 1'b1, op, ce, 1'b1);
    #1;
    snap(d, rv, st, re, hv, hd, cnt, fl, em, rdy);
    chk({tag, "_cmd_rdy"}, 128'(rdy), 128'(1'b1));
    @(posedge clk);
    #1;
    drive(d, 1'b0, op, ce, 1'b1);
    model_cmd(d, op, ce, last_st, last_re);
    check_all(d, tag, last_st, last_re);
  endtask

  initial begin
    logic rv, hv, fl, em, rdy;
    status_t st;
    table_t re, hd, ce;
    logic [4:0] cnt;
    table_op_t op;
    int d;

    m_n[0] = 0;
    m_n[1] = 0;
    arst_n = 1'b0;
    drive(0, 1'b0, Tbl_Insert, TABLE_BID_INIT, 1'b1);
    drive(1, 1'b0, Tbl_Insert, TABLE_ASK_INIT, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_idle(0, "rst_bid");
    check_idle(1, "rst_ask");
    @(negedge clk);
    arst_n = 1'b1;

    // Bid ordering: best (highest) price first.
    issue(0, Tbl_Insert, mk(1, 10000, 10), "bid_ins1");
    issue(0, Tbl_Insert, mk(2, 10200, 10), "bid_ins2");
    issue(0, Tbl_Insert, mk(3, 10100, 10), "bid_ins3");
    chk("bid_head_uid2", 128'(head_b.uid), 128'(2));
    issue(0, Tbl_PopTop, mk(0, 0, 0), "bid_pop1");
    chk("bid_pop1_uid", 128'(if_b.rsp_entry.uid), 128'(2));
    issue(0, Tbl_PopTop, mk(0, 0, 0), "bid_pop2");
    chk("bid_pop2_uid", 128'(if_b.rsp_entry.uid), 128'(3));
    issue(0, Tbl_PopTop, mk(0, 0, 0), "bid_pop3");
    chk("bid_pop3_uid", 128'(if_b.rsp_entry.uid), 128'(1));
    issue(0, Tbl_PopTop, mk(0, 0, 0), "bid_pop4");
    chk("bid_pop4_status", 128'(if_b.rsp_status), 128'(S_BadPop));

    // Capacity limits and invalid inserts.
    for (int i = 0; i < 4; i++) issue(0, Tbl_Insert, mk(10 + i, 9900 + 50 * i, 5), "bid_fill");
    issue(0, Tbl_Insert, mk(20, 12000, 5), "bid_over");
    chk("bid_over_status", 128'(if_b.rsp_status), 128'(S_Reject));
    chk("bid_over_count", 128'(count_b), 128'(4));
    chk("bid_over_full", 128'(full_b), 128'(1'b1));
    issue(0, Tbl_PopTop, mk(0, 0, 0), "bid_pop5");
    issue(0, Tbl_Insert, mk(21, 10000, 0), "bid_qty0");
    chk("bid_qty0_status", 128'(if_b.rsp_status), 128'(S_Reject));
    issue(0, Tbl_Insert, mk(-1, 10000, 5), "bid_uid_ones");
    chk("bid_uid_ones_status", 128'(if_b.rsp_status), 128'(S_Reject));
    chk("bid_uid_ones_count", 128'(count_b), 128'(3));

    // Ask side: FIFO at equal price, cancel hit and miss.
    issue(1, Tbl_Insert, mk(5, 5000, 10), "ask_ins5");
    issue(1, Tbl_Insert, mk(6, 5000, 10), "ask_ins6");
    chk("ask_head_uid5", 128'(head_a.uid), 128'(5));
    issue(1, Tbl_Cancel, mk(5, 0, 0), "ask_cxl5");
    chk("ask_cxl5_status", 128'(if_a.rsp_status), 128'(S_CancelHit));
    chk("ask_cxl5_head", 128'(head_a.uid), 128'(6));
    issue(1, Tbl_Cancel, mk(9, 0, 0), "ask_cxl9");
    chk("ask_cxl9_status", 128'(if_a.rsp_status), 128'(S_CancelMiss));
    issue(1, Tbl_PopTop, mk(0, 0, 0), "ask_pop6");

    // Partial fills of the head.
    issue(1, Tbl_Insert, mk(7, 4000, 100), "ask_ins7");
    issue(1, Tbl_HeadDec, mk(0, 0, 30), "ask_dec30");
    chk("ask_dec30_qty", 128'(head_a.quantity), 128'(70));
    issue(1, Tbl_HeadDec, mk(0, 0, 80), "ask_dec80");
    chk("ask_dec80_status", 128'(if_a.rsp_status), 128'(S_Bad));
    issue(1, Tbl_HeadDec, mk(0, 0, 70), "ask_dec70");
    chk("ask_dec70_rspqty", 128'(if_a.rsp_entry.quantity), 128'(0));
    chk("ask_dec70_count", 128'(count_a), 128'(0));

    // Backpressure: response held while not accepted, then back-to-back.
    issue(1, Tbl_Insert, mk(30, 6000, 8), "ask_hold_x");
    drive(1, 1'b1, Tbl_Insert, mk(31, 5900, 8), 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      snap(1, rv, st, re, hv, hd, cnt, fl, em, rdy);
      chk("hold_cmd_rdy", 128'(rdy), 128'(1'b0));
      chk("hold_rsp_vld", 128'(rv), 128'(1'b1));
      chk("hold_rsp_status", 128'(st), 128'(last_st));
      chk("hold_rsp_entry", 128'(re), 128'(last_re));
      chk("hold_count", 128'(cnt), 128'(m_n[1]));
    end
    drive(1, 1'b1, Tbl_Insert, mk(31, 5900, 8), 1'b1);
    @(posedge clk);
    #1;
    model_cmd(1, Tbl_Insert, mk(31, 5900, 8), st, re);
    check_all(1, "b2b_y", st, re);
    drive(1, 1'b1, Tbl_Insert, mk(32, 6100, 8), 1'b1);
    @(posedge clk);
    #1;
    model_cmd(1, Tbl_Insert, mk(32, 6100, 8), st, re);
    check_all(1, "b2b_z", st, re);
    drive(1, 1'b0, Tbl_Insert, mk(32, 6100, 8), 1'b1);

    // Randomised mix against the model.
    for (int i = 0; i < 400; i++) begin
      d = int'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = Tbl_Insert;
        4, 5:       op = Tbl_PopTop;
        6, 7:       op = Tbl_Cancel;
        default:    op = Tbl_HeadDec;
      endcase
      ce = mk(int'($urandom_range(1, 8)), 100 * int'($urandom_range(95, 105)),
              int'($urandom_range(0, 20)));
      if ($urandom_range(0, 19) == 0) ce.uid = '1;
      if (op == Tbl_HeadDec && m_n[d] > 0) begin
        case ($urandom_range(0, 3))
          0: ce.quantity = m_e[d][0].quantity;
          1: ce.quantity = m_e[d][0].quantity - 1;
          2: ce.quantity = m_e[d][0].quantity + 1;
          default: ;
        endcase
      end
      issue(d, op, ce, "rand");
    end

    // Asynchronous reset with a command in flight.
    while (m_n[0] > 0) issue(0, Tbl_PopTop, mk(0, 0, 0), "pre_rst_pop");
    issue(0, Tbl_Insert, mk(40, 10000, 5), "pre_rst_ins1");
    issue(0, Tbl_Insert, mk(41, 10100, 5), "pre_rst_ins2");
    issue(0, Tbl_Insert, mk(42, 9900, 5), "pre_rst_ins3");
    @(negedge clk);
    drive(0, 1'b1, Tbl_Insert, mk(43, 10000, 5), 1'b1);
    #2;
    arst_n = 1'b0;
    #1;
    m_n[0] = 0;
    m_n[1] = 0;
    check_idle(0, "midrst_bid");
    check_idle(1, "midrst_ask");
    drive(0, 1'b0, Tbl_Insert, mk(43, 10000, 5), 1'b1);
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("post_rst_count", 128'(count_b), 128'(0));
    chk("post_rst_head", 128'(head_b), 128'(TABLE_BID_INIT));
    issue(0, Tbl_Insert, mk(44, 10000, 5), "post_rst_ins");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
